// File: rtl/vproc_mem_responder.sv
// Word-organised memory responder for the vproc data-memory bus, fixed-latency in-order replies.
// Define VPROC_MEM_RESP_CNT_EN to add saturating read/write/error response counters.
module vproc_mem_responder #(
   parameter int unsigned MEM_W          = 32,
   parameter int unsigned MEM_SIZE_BYTES = 4096,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned LATENCY        = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vproc_mem_req_i,
   input  logic [31:0]        vproc_mem_addr_i,
   input  logic               vproc_mem_we_i,
   input  logic [MEM_W/8-1:0] vproc_mem_be_i,
   input  logic [MEM_W-1:0]   vproc_mem_wdata_i,
   output logic               vproc_mem_rvalid_o,
   output logic               vproc_mem_err_o,
   output logic [MEM_W-1:0]   vproc_mem_rdata_o,
   output logic [3:0]         mem_pending_o
`ifdef VPROC_MEM_RESP_CNT_EN
   ,
   output logic [31:0]        rd_cnt_o,
   output logic [31:0]        wr_cnt_o,
   output logic [31:0]        err_cnt_o
`endif
);

   localparam int unsigned BYTES = MEM_W / 8;
   localparam int unsigned WORDS = MEM_SIZE_BYTES / BYTES;
   localparam int unsigned OFS   = $clog2(BYTES);
   localparam int unsigned AW    = $clog2(WORDS);

   localparam logic [32:0] LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI = {1'b0, BASE_ADDR} + 33'(MEM_SIZE_BYTES);

   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("vproc_mem_responder: LATENCY must be 1..8");
   end
   if ((MEM_SIZE_BYTES & (MEM_SIZE_BYTES - 1)) != 0) begin : g_bad_size
      $error("vproc_mem_responder: MEM_SIZE_BYTES must be a power of two");
   end

   logic [32:0]      addr_x;
   logic [31:0]      offset;
   logic [AW-1:0]    idx;
   logic             in_range;
   logic             unused_offset;
   logic             wr_hit;
   logic             rd_hit;
   logic [MEM_W-1:0] rd_word;

   logic [MEM_W-1:0] mem_q [WORDS];

   logic [LATENCY-1:0] pv;
   logic [LATENCY-1:0] pe;
   logic [LATENCY-1:0] pw;
   logic [MEM_W-1:0]   pd [LATENCY];

   // 33-bit compare so BASE_ADDR + size cannot wrap
   assign addr_x        = {1'b0, vproc_mem_addr_i};
   assign in_range      = (addr_x >= LO) && (addr_x < HI);
   assign offset        = vproc_mem_addr_i - BASE_ADDR;
   assign idx           = offset[OFS +: AW];
   assign unused_offset = ^offset;

   assign wr_hit  = vproc_mem_req_i && vproc_mem_we_i && in_range;
   assign rd_hit  = vproc_mem_req_i && !vproc_mem_we_i && in_range;
   assign rd_word = rd_hit ? mem_q[idx] : '0;

   always_ff @(posedge clk) begin
      if (wr_hit) begin
         for (int b = 0; b < BYTES; b++) begin
            if (vproc_mem_be_i[b]) begin
               mem_q[idx][b*8 +: 8] <= vproc_mem_wdata_i[b*8 +: 8];
            end
         end
      end
   end

   // Read data is captured at acceptance, so later writes cannot alter it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv <= '0;
         pe <= '0;
         pw <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pd[i] <= '0;
         end
      end else begin
         pv[0] <= vproc_mem_req_i;
         pe[0] <= vproc_mem_req_i && !in_range;
         pw[0] <= vproc_mem_req_i && vproc_mem_we_i;
         pd[0] <= rd_word;
         for (int i = 1; i < LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pw[i] <= pw[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end

   assign vproc_mem_rvalid_o = pv[LATENCY-1];
   assign vproc_mem_err_o    = pe[LATENCY-1];
   assign vproc_mem_rdata_o  = pd[LATENCY-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_pending_o <= '0;
      end else begin
         case ({vproc_mem_req_i, vproc_mem_rvalid_o})
            2'b10:   mem_pending_o <= mem_pending_o + 4'd1;
            2'b01:   mem_pending_o <= mem_pending_o - 4'd1;
            default: mem_pending_o <= mem_pending_o;
         endcase
      end
   end

`ifdef VPROC_MEM_RESP_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_o  <= '0;
         wr_cnt_o  <= '0;
         err_cnt_o <= '0;
      end else if (vproc_mem_rvalid_o) begin
         if (vproc_mem_err_o) begin
            err_cnt_o <= sat_inc(err_cnt_o);
         end else if (pw[LATENCY-1]) begin
            wr_cnt_o <= sat_inc(wr_cnt_o);
         end else begin
            rd_cnt_o <= sat_inc(rd_cnt_o);
         end
      end
   end
`endif

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Directed self-checking bench for vproc_mem_responder (LATENCY=2, 4 KiB).
module tb_vproc_mem_responder;

   logic        clk;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic        err;
   logic [31:0] rdata;
   logic [3:0]  pending;

   logic        req2;
   logic [31:0] addr2;
   logic        we2;
   logic        rvalid2;
   logic        err2;
   logic [31:0] rdata2;
   logic [3:0]  pending2;

`ifdef VPROC_MEM_RESP_CNT_EN
   logic [31:0] rd_cnt, wr_cnt, err_cnt;
   logic [31:0] rd_cnt2, wr_cnt2, err_cnt2;
`endif

   int checks = 0;
   int errors = 0;

   vproc_mem_responder #(
      .MEM_W(32), .MEM_SIZE_BYTES(4096),
      .BASE_ADDR(32'h0000_0000), .LATENCY(2)
   ) dut (
      .clk(clk), .rst(rst),
      .vproc_mem_req_i(req), .vproc_mem_addr_i(addr),
      .vproc_mem_we_i(we), .vproc_mem_be_i(be),
      .vproc_mem_wdata_i(wdata),
      .vproc_mem_rvalid_o(rvalid), .vproc_mem_err_o(err),
      .vproc_mem_rdata_o(rdata), .mem_pending_o(pending)
`ifdef VPROC_MEM_RESP_CNT_EN
      , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .err_cnt_o(err_cnt)
`endif
   );

   vproc_mem_responder #(
      .MEM_W(32), .MEM_SIZE_BYTES(4096),
      .BASE_ADDR(32'h8000_0000), .LATENCY(2)
   ) dut2 (
      .clk(clk), .rst(rst),
      .vproc_mem_req_i(req2), .vproc_mem_addr_i(addr2),
      .vproc_mem_we_i(we2), .vproc_mem_be_i(be),
      .vproc_mem_wdata_i(wdata),
      .vproc_mem_rvalid_o(rvalid2), .vproc_mem_err_o(err2),
      .vproc_mem_rdata_o(rdata2), .mem_pending_o(pending2)
`ifdef VPROC_MEM_RESP_CNT_EN
      , .rd_cnt_o(rd_cnt2), .wr_cnt_o(wr_cnt2), .err_cnt_o(err_cnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
      req   = 1'b1;
      we    = w;
      addr  = a;
      be    = b;
      wdata = d;
   endtask

   task automatic idle();
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      be    = '0;
      wdata = '0;
   endtask

   // One isolated transaction: accept, wait LATENCY, check response, drain
   task automatic xact(input string tag, input logic w,
                       input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic exp_err,
                       input logic [31:0] exp_data);
      put(w, a, b, d);
      tick();
      idle();
      tick();
      chk({tag, ".rvalid"}, {31'd0, rvalid}, 32'd1);
      chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
      chk({tag, ".rdata"}, rdata, exp_data);
      tick();
      chk({tag, ".rvalid_off"}, {31'd0, rvalid}, 32'd0);
      chk({tag, ".pending"}, {28'd0, pending}, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      req2  = 1'b0;
      addr2 = '0;
      we2   = 1'b0;
      idle();
      #7;
      chk("reset.rvalid", {31'd0, rvalid}, 32'd0);
      chk("reset.err", {31'd0, err}, 32'd0);
      chk("reset.rdata", rdata, 32'd0);
      chk("reset.pending", {28'd0, pending}, 32'd0);
      rst = 1'b0;

      put(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      tick();
      chk("wr_rd.pend1", {28'd0, pending}, 32'd1);
      chk("wr_rd.early", {31'd0, rvalid}, 32'd0);
      put(1'b0, 32'h10, 4'h0, 32'h0);
      tick();
      chk("wr_rd.wresp_v", {31'd0, rvalid}, 32'd1);
      chk("wr_rd.wresp_e", {31'd0, err}, 32'd0);
      chk("wr_rd.wresp_d", rdata, 32'd0);
      chk("wr_rd.pend2", {28'd0, pending}, 32'd2);
      idle();
      tick();
      chk("wr_rd.rresp_v", {31'd0, rvalid}, 32'd1);
      chk("wr_rd.rresp_e", {31'd0, err}, 32'd0);
      chk("wr_rd.rresp_d", rdata, 32'hDEAD_BEEF);
      chk("wr_rd.pend3", {28'd0, pending}, 32'd1);
      tick();
      chk("wr_rd.done_v", {31'd0, rvalid}, 32'd0);
      chk("wr_rd.pend0", {28'd0, pending}, 32'd0);

      xact("be.pre", 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, 32'd0);
      xact("be.wr", 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0, 32'd0);
      xact("be.rd", 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h11BB_33DD);
      xact("be0.wr", 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'd0);
      xact("be0.rd", 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h11BB_33DD);

      for (int i = 0; i < 16; i++) begin
         put(1'b1, 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i));
         tick();
      end
      idle();
      tick();
      tick();
      tick();

      for (int i = 0; i <= 16; i++) begin
         if (i < 16) put(1'b0, 32'(i * 4), 4'h0, 32'h0);
         else idle();
         tick();
         if (i == 0) begin
            chk("stream.first_v", {31'd0, rvalid}, 32'd0);
            chk("stream.first_p", {28'd0, pending}, 32'd1);
         end else begin
            chk($sformatf("stream.v%0d", i - 1), {31'd0, rvalid}, 32'd1);
            chk($sformatf("stream.d%0d", i - 1), rdata,
                32'hC0DE_0000 + 32'(i - 1));
            if (i <= 15) begin
               chk($sformatf("stream.p%0d", i), {28'd0, pending}, 32'd2);
            end
         end
      end
      chk("stream.tail_p", {28'd0, pending}, 32'd1);
      tick();
      chk("stream.end_v", {31'd0, rvalid}, 32'd0);
      chk("stream.end_p", {28'd0, pending}, 32'd0);

      xact("oor.rd", 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'd0);
      xact("oor.wr", 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h1234_5678, 1'b1, 32'd0);
      xact("oor.clean", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'hC0DE_0000);
      xact("top.wr", 1'b1, 32'hFFC, 4'hF, 32'h7777_8888, 1'b0, 32'd0);
      xact("top.rd", 1'b0, 32'hFFC, 4'h0, 32'h0, 1'b0, 32'h7777_8888);
      xact("misalign", 1'b0, 32'h13, 4'h0, 32'h0, 1'b0, 32'hC0DE_0004);

      req2 = 1'b1; we2 = 1'b0; addr2 = 32'h7FFF_FFFC;
      tick();
      req2 = 1'b0;
      tick();
      chk("base.below_v", {31'd0, rvalid2}, 32'd1);
      chk("base.below_e", {31'd0, err2}, 32'd1);
      chk("base.below_d", rdata2, 32'd0);
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h8000_0004;
      be = 4'hF; wdata = 32'h55AA_55AA;
      tick();
      we2 = 1'b0; be = 4'h0; wdata = '0;
      tick();
      req2 = 1'b0;
      tick();
      chk("base.in_v", {31'd0, rvalid2}, 32'd1);
      chk("base.in_e", {31'd0, err2}, 32'd0);
      chk("base.in_d", rdata2, 32'h55AA_55AA);
      tick();
      chk("base.pend", {28'd0, pending2}, 32'd0);

      xact("rstmf.wr", 1'b1, 32'h40, 4'hF, 32'h0BAD_F00D, 1'b0, 32'd0);
      put(1'b0, 32'h0, 4'h0, 32'h0);
      tick();
      put(1'b0, 32'h4, 4'h0, 32'h0);
      tick();
      idle();
      chk("rstmf.inflight", {31'd0, rvalid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmf.drop_v", {31'd0, rvalid}, 32'd0);
      chk("rstmf.drop_p", {28'd0, pending}, 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rstmf.quiet%0d", i), {31'd0, rvalid}, 32'd0);
      end
      xact("rstmf.keep", 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h0BAD_F00D);

`ifdef VPROC_MEM_RESP_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("cnt.rst_rd", rd_cnt, 32'd0);
      xact("cnt.r0", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'hC0DE_0000);
      xact("cnt.w0", 1'b1, 32'h80, 4'hF, 32'h0000_0001, 1'b0, 32'd0);
      xact("cnt.r1", 1'b0, 32'h4, 4'h0, 32'h0, 1'b0, 32'hC0DE_0001);
      xact("cnt.e0", 1'b0, 32'h2000, 4'h0, 32'h0, 1'b1, 32'd0);
      xact("cnt.w1", 1'b1, 32'h84, 4'h3, 32'h0000_0002, 1'b0, 32'd0);
      xact("cnt.r2", 1'b0, 32'h80, 4'h0, 32'h0, 1'b0, 32'h0000_0001);
      chk("cnt.rd", rd_cnt, 32'd3);
      chk("cnt.wr", wr_cnt, 32'd2);
      chk("cnt.err", err_cnt, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
